dmem_responder: RTL and testbench

- Data-memory responder: the target end of the processor's load/store port.
- Accepts one request (load or store) at a time over a valid/ready handshake.
- Performs the access on an internal word-organised RAM after a fixed, parameterised latency.
- Returns the result over a second valid/ready handshake. Lets the core be tested against non-ideal, multi-cycle memory.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Load/store port between a processor core (master) and its data memory (slave).
// Request and response each use an independent valid/ready handshake.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store target with a word RAM
// and a fixed, parameterised access latency between request and response.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic   clk,
    input  logic   reset_n,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        acc_en;

    logic        we_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;
    logic [3:0]  wstrb_p0;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        acc_fault;
    logic [AW-1:0] acc_idx;

    logic [31:0] mem [DEPTH];

    function automatic logic is_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != 32'd0);
    endfunction

    // With zero latency the access happens on the accepting edge, so it must
    // use the live request fields rather than the not-yet-loaded capture.
    always_comb begin
        acc_we    = we_p0;
        acc_addr  = addr_p0;
        acc_wdata = wdata_p0;
        acc_wstrb = wstrb_p0;
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_wstrb = bus.req_wstrb;
        end
    end

    assign acc_fault = is_fault(acc_addr);
    assign acc_idx   = acc_addr[AW+1:2];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        acc_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        acc_en     = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = 4'(LATENCY - 1);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    acc_en     = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bus.req_ready <= (state_next == IDLE);
            bus.rsp_valid <= (state_next == RESP);
            if (acc_en) begin
                bus.rsp_err   <= acc_fault;
                bus.rsp_rdata <= (!acc_fault && !acc_we) ? mem[acc_idx] : 32'd0;
            end else if (state == RESP && bus.rsp_ready) begin
                bus.rsp_err   <= 1'b0;
                bus.rsp_rdata <= 32'd0;
            end
        end
    end

    // ---- capture stage: request fields held for the duration of the access
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            we_p0    <= bus.req_we;
            addr_p0  <= bus.req_addr;
            wdata_p0 <= bus.req_wdata;
            wstrb_p0 <= bus.req_wstrb;
        end
    end

    // RAM is not reset; writes are blocked while reset is held
    always_ff @(posedge clk) begin
        if (reset_n && acc_en && acc_we && !acc_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (latency 2 and latency 0) driven
// through one requester, with a queue-based scoreboard and a reference RAM.
module tb_dmem_responder;
    localparam int LAT0 = 2;
    localparam int LAT1 = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_ready;

    dmem_if bus0();
    dmem_if bus1();

    dmem_responder #(.DEPTH(256), .LATENCY(LAT0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    dmem_responder #(.DEPTH(256), .LATENCY(LAT1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    assign bus0.req_valid = req_valid & ~sel;
    assign bus1.req_valid = req_valid & sel;
    assign bus0.req_we    = req_we;
    assign bus1.req_we    = req_we;
    assign bus0.req_addr  = req_addr;
    assign bus1.req_addr  = req_addr;
    assign bus0.req_wdata = req_wdata;
    assign bus1.req_wdata = req_wdata;
    assign bus0.req_wstrb = req_wstrb;
    assign bus1.req_wstrb = req_wstrb;
    assign bus0.rsp_ready = rsp_ready;
    assign bus1.rsp_ready = rsp_ready;

    logic        req_ready_m;
    logic        rsp_valid_m;
    logic [31:0] rsp_rdata_m;
    logic        rsp_err_m;
    assign req_ready_m = sel ? bus1.req_ready : bus0.req_ready;
    assign rsp_valid_m = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign rsp_rdata_m = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    assign rsp_err_m   = sel ? bus1.rsp_err   : bus0.rsp_err;

    int          passed = 0;
    int          total  = 0;
    int          n_rsp  = 0;
    int          n0;
    logic [31:0] last_rdata = 32'd0;
    logic        last_err   = 1'b0;
    logic [31:0] held;
    exp_t        sb[$];
    exp_t        tmp;
    logic [31:0] model [2][256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic exp_t predict(input logic s, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        int   idx;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        if (addr[1:0] != 2'b00 || addr >= 32'h400) begin
            e.err = 1'b1;
        end else begin
            idx = int'(addr[9:2]);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) model[s][idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                e.rdata = model[s][idx];
            end
        end
        return e;
    endfunction

    // Response monitor: every handshake retires the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && rsp_valid_m && rsp_ready) begin
            total++;
            assert (sb.size() != 0) begin
                passed++;
                tmp = sb.pop_front();
                check("rsp_rdata", rsp_rdata_m, tmp.rdata);
                check("rsp_err", 32'(rsp_err_m), 32'(tmp.err));
            end else $error("FAIL unexpected_rsp: observed rdata 0x%08h with empty scoreboard", rsp_rdata_m);
            last_rdata = rsp_rdata_m;
            last_err   = rsp_err_m;
            n_rsp++;
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic push);
        logic acc;
        if (push) sb.push_back(predict(sel, we, addr, wdata, wstrb));
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) begin
            acc = req_ready_m;
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        #1;
        req_valid = 1'b0;
        req_we    = 1'bx;
        req_addr  = 'x;
        req_wdata = 'x;
        req_wstrb = 'x;
        total++;
        assert (acc) passed++;
        else $error("FAIL accept_timeout: observed req_ready 0 expected 1 within 64 cycles");
    endtask

    task automatic lat_check(input string tag);
        int lat = 1;
        while (!rsp_valid_m && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(tag, 32'(lat), 32'((sel ? LAT1 : LAT0) + 1));
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_wstrb = 4'd0;
        rsp_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus0.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus0.rsp_err), 32'd0);
        check("rst_req_ready_l0", 32'(bus1.req_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Full-word store then load back
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        lat_check("lat_store_l2");
        drain();
        check("store_rdata_zero", last_rdata, 32'd0);
        check("store_err_zero", 32'(last_err), 32'd0);
        send(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
        drain();
        check("load_deadbeef", last_rdata, 32'hDEADBEEF);

        // Byte-lane merge and empty-strobe store
        send(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1);
        drain();
        send(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
        drain();
        check("load_merged", last_rdata, 32'hDE22BE44);
        send(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1);
        drain();
        check("wstrb0_err", 32'(last_err), 32'd0);
        send(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
        drain();
        check("wstrb0_noop", last_rdata, 32'hDE22BE44);

        // Faults: misaligned, out of range, and faulting stores leave RAM alone
        send(1'b0, 32'h13, 32'd0, 4'h0, 1'b1);
        drain();
        check("misaligned_err", 32'(last_err), 32'd1);
        check("misaligned_rdata", last_rdata, 32'd0);
        send(1'b0, 32'h400, 32'd0, 4'h0, 1'b1);
        drain();
        check("range_err", 32'(last_err), 32'd1);
        send(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 1'b1);
        send(1'b1, 32'h410, 32'hFFFFFFFF, 4'hF, 1'b1);
        drain();
        send(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
        drain();
        check("fault_ram_unchanged", last_rdata, 32'hDE22BE44);

        // Response back-pressure while the requester keeps poking req_valid
        rsp_ready = 1'b0;
        send(1'b0, 32'h10, 32'd0, 4'h0, 1'b1);
        lat_check("lat_hold");
        held = rsp_rdata_m;
        check("hold_value", held, 32'hDE22BE44);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_we    = 1'b0;
            req_addr  = 32'h10;
            req_wstrb = 4'h0;
            req_valid = ~req_valid;
            @(posedge clk);
            #1;
            check("hold_rsp_valid", 32'(rsp_valid_m), 32'd1);
            check("hold_rsp_rdata", rsp_rdata_m, held);
            check("hold_req_ready", 32'(req_ready_m), 32'd0);
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_wdata = 32'd0;
        req_wstrb = 4'h0;
        sb.push_back(predict(sel, 1'b0, 32'h10, 32'd0, 4'h0));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("retire_req_ready", 32'(req_ready_m), 32'd1);
        check("retire_rsp_valid", 32'(rsp_valid_m), 32'd0);
        @(posedge clk);
        #1;
        check("accept_after_retire", 32'(req_ready_m), 32'd0);
        req_valid = 1'b0;
        drain();
        check("post_hold_load", last_rdata, 32'hDE22BE44);

        // Zero-latency instance: latency and an in-order stream of 8
        sel = 1'b1;
        send(1'b1, 32'h40, 32'h01020304, 4'hF, 1'b1);
        lat_check("lat_l0");
        drain();
        n0 = n_rsp;
        send(1'b1, 32'h80, 32'hA0A0A0A0, 4'hF, 1'b1);
        send(1'b1, 32'h84, 32'hB1B2B3B4, 4'hF, 1'b1);
        send(1'b0, 32'h80, 32'd0, 4'h0, 1'b1);
        send(1'b1, 32'h88, 32'h0BADF00D, 4'hF, 1'b1);
        send(1'b0, 32'h84, 32'd0, 4'h0, 1'b1);
        send(1'b1, 32'h80, 32'h12345678, 4'b1100, 1'b1);
        send(1'b0, 32'h80, 32'd0, 4'h0, 1'b1);
        send(1'b0, 32'h88, 32'd0, 4'h0, 1'b1);
        drain();
        check("stream_count", 32'(n_rsp - n0), 32'd8);
        check("stream_last", last_rdata, 32'h0BADF00D);
        send(1'b0, 32'h80, 32'd0, 4'h0, 1'b1);
        drain();
        check("stream_merge", last_rdata, 32'h1234A0A0);
        sel = 1'b0;

        // Reset while a store waits: the store is discarded
        send(1'b1, 32'h20, 32'h00000000, 4'hF, 1'b1);
        drain();
        send(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0);
        reset_n = 1'b0;
        #1;
        check("wait_rst_req_ready", 32'(bus0.req_ready), 32'd1);
        check("wait_rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("wait_rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send(1'b0, 32'h20, 32'd0, 4'h0, 1'b1);
        drain();
        check("wait_rst_discard", last_rdata, 32'h00000000);

        // Reset while a store response is pending: the store stays committed
        rsp_ready = 1'b0;
        send(1'b1, 32'h24, 32'h5A5A5A5A, 4'hF, 1'b1);
        lat_check("lat_resp_rst");
        reset_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("resp_rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("resp_rst_req_ready", 32'(bus0.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        send(1'b0, 32'h24, 32'd0, 4'h0, 1'b1);
        drain();
        check("resp_rst_committed", last_rdata, 32'h5A5A5A5A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
